// File: rtl/lcd_pkg.sv
// Shared LCD definitions: transmitter FSM states, ST7789 command bytes, RGB565 colours.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } lcd_state_t;

  // ST7789 window / memory-write commands
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // RGB565 colours
  localparam logic [15:0] RGB_BLACK   = 16'h0000;
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;

  // Build a 9-bit transmitter word: bit 8 is DC (0 command, 1 data).
  function automatic logic [8:0] lcd_word(input logic is_data, input logic [7:0] byte_val);
    return {is_data, byte_val};
  endfunction

endpackage

// File: rtl/lcd_spi_tick.sv
// SCL half-period divider: one-cycle half_tick every CLK_DIV cycles while enabled.
// Latency: first half_tick in the CLK_DIV-th cycle after enable rises.
// Backpressure: none; counter clears whenever en is low or on sys_rst.
module lcd_spi_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic half_tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running count while enabled, wrapping at the half-period boundary.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half_tick = en && (cnt == LAST);

endmodule

// File: rtl/lcd_spi_write.sv
// Byte-level 4-wire SPI write to the LCD: 9-bit {DC,byte} word out MSB-first, SPI mode 0.
// Latency: wr_done at 18*CLK_DIV edges after acceptance; next word 1+GAP_CYCLES edges later.
// Backpressure: en_write is a level request sampled only in IDLE; busy high while a word is in flight.
module lcd_spi_write
  import lcd_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs_n,
  output logic       lcd_scl,
  output logic       lcd_sda,
  output logic       lcd_dc
);

  // GAP state covers all idle cycles but the last one, which is spent in IDLE
  // (or in DONE itself when there is no gap at all).
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);

  lcd_state_t state, state_nxt;

  logic [7:0] shreg, shreg_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic       cs_n_nxt, scl_nxt, dc_nxt, done_nxt, busy_nxt;
  logic       accept;
  logic       tick_en, half_tick;

  assign tick_en = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);

  lcd_spi_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (tick_en),
    .half_tick(half_tick)
  );

  // The MSB of the shift register drives the data pin directly.
  assign lcd_sda = shreg[7];

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output decode; acceptance overrides the per-state decode.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    cs_n_nxt    = lcd_cs_n;
    scl_nxt     = lcd_scl;
    dc_nxt      = lcd_dc;
    done_nxt    = 1'b0;
    accept      = en_write && ((state == ST_IDLE) || ((state == ST_DONE) && (GAP_CYCLES == 0)));

    case (state)
      ST_IDLE: begin
        state_nxt = ST_IDLE;
      end
      ST_SETUP: begin
        if (half_tick) begin
          scl_nxt     = 1'b1;
          bit_cnt_nxt = 3'd0;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (half_tick) begin
          if (lcd_scl) begin
            // Falling edge: present the next bit, except after the last one.
            scl_nxt = 1'b0;
            if (bit_cnt != 3'd7) begin
              shreg_nxt = {shreg[6:0], 1'b0};
            end
          end else if (bit_cnt == 3'd7) begin
            state_nxt = ST_HOLD;
          end else begin
            scl_nxt     = 1'b1;
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      ST_HOLD: begin
        if (half_tick) begin
          cs_n_nxt  = 1'b1;
          done_nxt  = 1'b1;
          dc_nxt    = 1'b0;
          shreg_nxt = '0;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (GAP_CYCLES <= 1) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = 8'd0;
          state_nxt   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (accept) begin
      shreg_nxt   = data[7:0];
      dc_nxt      = data[8];
      cs_n_nxt    = 1'b0;
      scl_nxt     = 1'b0;
      bit_cnt_nxt = 3'd0;
      state_nxt   = ST_SETUP;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // Datapath and pin registers; reset discards any partial byte.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      lcd_cs_n <= 1'b1;
      lcd_scl  <= 1'b0;
      lcd_dc   <= 1'b0;
      wr_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      lcd_cs_n <= cs_n_nxt;
      lcd_scl  <= scl_nxt;
      lcd_dc   <= dc_nxt;
      wr_done  <= done_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Directed bench for lcd_spi_write: default build (CLK_DIV=2, GAP=4) and corner build (CLK_DIV=1, GAP=0).
// Edge numbers are counted by cyc; outputs are sampled on the falling clock edge.
// Each scenario task drives its own stimulus and compares against hand-derived timing.
module tb_lcd_spi_write;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [8:0] data_a, data_b;
  logic       en_a, en_b;
  logic       a_wr_done, a_busy, a_cs_n, a_scl, a_sda, a_dc;
  logic       b_wr_done, b_busy, b_cs_n, b_scl, b_sda, b_dc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dc_err = 0;

  // Observation logs filled by the monitors below.
  int   a_rise_cyc[$];
  logic a_rise_sda[$];
  logic a_rise_dc[$];
  logic a_rise_cs[$];
  int   a_done_cyc[$];
  int   a_acc_cyc[$];
  int   b_rise_cyc[$];
  logic b_rise_sda[$];
  logic b_rise_dc[$];
  int   b_done_cyc[$];
  int   b_acc_cyc[$];
  logic a_scl_q = 1'b0, a_cs_q = 1'b1, a_dc_q = 1'b0;
  logic b_scl_q = 1'b0, b_cs_q = 1'b1, b_dc_q = 1'b0;

  lcd_spi_write #(.CLK_DIV(2), .GAP_CYCLES(4)) dut_a (
    .sys_clk(clk), .sys_rst(sys_rst), .data(data_a), .en_write(en_a),
    .wr_done(a_wr_done), .busy(a_busy), .lcd_cs_n(a_cs_n),
    .lcd_scl(a_scl), .lcd_sda(a_sda), .lcd_dc(a_dc)
  );

  lcd_spi_write #(.CLK_DIV(1), .GAP_CYCLES(0)) dut_b (
    .sys_clk(clk), .sys_rst(sys_rst), .data(data_b), .en_write(en_b),
    .wr_done(b_wr_done), .busy(b_busy), .lcd_cs_n(b_cs_n),
    .lcd_scl(b_scl), .lcd_sda(b_sda), .lcd_dc(b_dc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log SCL rises (with SDA/DC/CS), wr_done pulses, CS falls, and DC changes inside a CS-low window.
  always @(negedge clk) begin
    if (a_scl === 1'b1 && a_scl_q === 1'b0) begin
      a_rise_cyc.push_back(cyc); a_rise_sda.push_back(a_sda);
      a_rise_dc.push_back(a_dc); a_rise_cs.push_back(a_cs_n);
    end
    if (a_wr_done === 1'b1) a_done_cyc.push_back(cyc);
    if (a_cs_n === 1'b0 && a_cs_q === 1'b1) a_acc_cyc.push_back(cyc);
    if (a_cs_n === 1'b0 && a_cs_q === 1'b0 && a_dc !== a_dc_q) dc_err++;
    if (b_scl === 1'b1 && b_scl_q === 1'b0) begin
      b_rise_cyc.push_back(cyc); b_rise_sda.push_back(b_sda); b_rise_dc.push_back(b_dc);
    end
    if (b_wr_done === 1'b1) b_done_cyc.push_back(cyc);
    if (b_cs_n === 1'b0 && b_cs_q === 1'b1) b_acc_cyc.push_back(cyc);
    if (b_cs_n === 1'b0 && b_cs_q === 1'b0 && b_dc !== b_dc_q) dc_err++;
    a_scl_q = a_scl; a_cs_q = a_cs_n; a_dc_q = a_dc;
    b_scl_q = b_scl; b_cs_q = b_cs_n; b_dc_q = b_dc;
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clear_logs();
    a_rise_cyc.delete(); a_rise_sda.delete(); a_rise_dc.delete(); a_rise_cs.delete();
    a_done_cyc.delete(); a_acc_cyc.delete();
    b_rise_cyc.delete(); b_rise_sda.delete(); b_rise_dc.delete();
    b_done_cyc.delete(); b_acc_cyc.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; en_a = 1'b1; data_a = 9'h1FF; en_b = 1'b1; data_b = 9'h1FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({a_cs_n, a_scl, a_sda, a_dc, a_wr_done, a_busy} !== 6'b100000) begin
        failures++;
        $display("FAIL reset_a%0d pins=%b exp=100000", i, {a_cs_n, a_scl, a_sda, a_dc, a_wr_done, a_busy});
      end
      checks++;
      if ({b_cs_n, b_scl, b_sda, b_dc, b_wr_done, b_busy} !== 6'b100000) begin
        failures++;
        $display("FAIL reset_b%0d pins=%b exp=100000", i, {b_cs_n, b_scl, b_sda, b_dc, b_wr_done, b_busy});
      end
    end
    sys_rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    clear_logs();
    wait_cyc(cyc + 6);
    checks++;
    if (a_rise_cyc.size() + b_rise_cyc.size() != 0 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle rises=%0d busy=%b%b exp rises=0 busy=00",
               a_rise_cyc.size() + b_rise_cyc.size(), a_busy, b_busy);
    end
  endtask

  task automatic test_single_cmd();
    int k;
    logic [7:0] b;
    b = 8'h2A;
    clear_logs();
    data_a = 9'h02A; en_a = 1'b1; k = cyc + 1;
    @(negedge clk); en_a = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_cs_n !== 1'b0) begin
      failures++; $display("FAIL single_accept busy=%b cs_n=%b exp busy=1 cs_n=0", a_busy, a_cs_n);
    end
    wait_cyc(k + 36);
    checks++;
    if (a_wr_done !== 1'b1 || a_cs_n !== 1'b1) begin
      failures++; $display("FAIL single_done_k36 wr_done=%b cs_n=%b exp 1 1", a_wr_done, a_cs_n);
    end
    wait_cyc(k + 37);
    checks++;
    if (a_wr_done !== 1'b0) begin
      failures++; $display("FAIL single_done_width wr_done=%b exp 0", a_wr_done);
    end
    wait_cyc(k + 39);
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL single_busy_gap busy=%b exp 1", a_busy); end
    wait_cyc(k + 40);
    checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL single_busy_idle busy=%b exp 0", a_busy); end
    wait_cyc(k + 45);
    checks++;
    if (a_done_cyc.size() != 1 || a_acc_cyc.size() != 1 || a_rise_cyc.size() != 8) begin
      failures++;
      $display("FAIL single_counts done=%0d acc=%0d rises=%0d exp 1 1 8",
               a_done_cyc.size(), a_acc_cyc.size(), a_rise_cyc.size());
    end else begin
      checks++;
      if (a_acc_cyc[0] != k) begin failures++; $display("FAIL single_acc cyc=%0d exp=%0d", a_acc_cyc[0], k); end
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (a_rise_cyc[n] != k + (2 * n + 1) * 2 ||
            {a_rise_sda[n], a_rise_dc[n], a_rise_cs[n]} !== {b[7-n], 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL single_rise%0d cyc=%0d sda/dc/cs=%b exp cyc=%0d sda/dc/cs=%b", n, a_rise_cyc[n],
                   {a_rise_sda[n], a_rise_dc[n], a_rise_cs[n]}, k + (2 * n + 1) * 2, {b[7-n], 2'b00});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k1, k2, kk, m;
    logic expb;
    clear_logs();
    data_a = 9'h1FF; en_a = 1'b1; k1 = cyc + 1; k2 = k1 + 41;
    wait_cyc(k1 + 39); data_a = 9'h100;
    wait_cyc(k2); en_a = 1'b0;
    wait_cyc(k2 + 45);
    checks++;
    if (a_acc_cyc.size() != 2 || a_done_cyc.size() != 2 || a_rise_cyc.size() != 16) begin
      failures++;
      $display("FAIL b2b_counts acc=%0d done=%0d rises=%0d exp 2 2 16",
               a_acc_cyc.size(), a_done_cyc.size(), a_rise_cyc.size());
    end else begin
      checks++;
      if (a_acc_cyc[0] != k1 || a_acc_cyc[1] != k2) begin
        failures++; $display("FAIL b2b_acc cyc=%0d,%0d exp=%0d,%0d", a_acc_cyc[0], a_acc_cyc[1], k1, k2);
      end
      checks++;
      if (a_done_cyc[0] != k1 + 36 || a_done_cyc[1] != k2 + 36) begin
        failures++;
        $display("FAIL b2b_done cyc=%0d,%0d exp=%0d,%0d", a_done_cyc[0], a_done_cyc[1], k1 + 36, k2 + 36);
      end
      for (int n = 0; n < 16; n++) begin
        kk = (n < 8) ? k1 : k2;
        m = n % 8;
        expb = (n < 8) ? 1'b1 : 1'b0;
        checks++;
        if (a_rise_cyc[n] != kk + (2 * m + 1) * 2 || a_rise_sda[n] !== expb || a_rise_dc[n] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_rise%0d cyc=%0d sda=%b dc=%b exp cyc=%0d sda=%b dc=1", n, a_rise_cyc[n],
                   a_rise_sda[n], a_rise_dc[n], kk + (2 * m + 1) * 2, expb);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    int k;
    logic [7:0] b;
    b = 8'hC3;
    clear_logs();
    data_a = 9'h0C3; en_a = 1'b1; k = cyc + 1;
    @(negedge clk); en_a = 1'b0;
    wait_cyc(k + 9); data_a = 9'h0AA; en_a = 1'b1;
    wait_cyc(k + 10); en_a = 1'b0;
    wait_cyc(k + 45);
    checks++;
    if (a_acc_cyc.size() != 1 || a_done_cyc.size() != 1 || a_rise_cyc.size() != 8) begin
      failures++;
      $display("FAIL mid_counts acc=%0d done=%0d rises=%0d exp 1 1 8",
               a_acc_cyc.size(), a_done_cyc.size(), a_rise_cyc.size());
    end else begin
      checks++;
      if (a_done_cyc[0] != k + 36) begin failures++; $display("FAIL mid_done cyc=%0d exp=%0d", a_done_cyc[0], k + 36); end
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (a_rise_sda[n] !== b[7-n] || a_rise_dc[n] !== 1'b0) begin
          failures++;
          $display("FAIL mid_bit%0d sda=%b dc=%b exp sda=%b dc=0", n, a_rise_sda[n], a_rise_dc[n], b[7-n]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k, k2;
    logic [7:0] b;
    b = 8'h3C;
    clear_logs();
    data_a = 9'h155; en_a = 1'b1; k = cyc + 1;
    @(negedge clk); en_a = 1'b0;
    wait_cyc(k + 14); sys_rst = 1'b1;
    wait_cyc(k + 15);
    checks++;
    if ({a_cs_n, a_scl, a_sda, a_dc, a_wr_done, a_busy} !== 6'b100000) begin
      failures++;
      $display("FAIL rstmid_pins pins=%b exp=100000", {a_cs_n, a_scl, a_sda, a_dc, a_wr_done, a_busy});
    end
    sys_rst = 1'b0;
    wait_cyc(k + 50);
    checks++;
    if (a_done_cyc.size() != 0 || a_rise_cyc.size() != 4) begin
      failures++;
      $display("FAIL rstmid_aborted done=%0d rises=%0d exp 0 4", a_done_cyc.size(), a_rise_cyc.size());
    end
    clear_logs();
    data_a = 9'h13C; en_a = 1'b1; k2 = cyc + 1;
    @(negedge clk); en_a = 1'b0;
    wait_cyc(k2 + 45);
    checks++;
    if (a_done_cyc.size() != 1 || a_rise_cyc.size() != 8) begin
      failures++;
      $display("FAIL rstmid_retry_counts done=%0d rises=%0d exp 1 8", a_done_cyc.size(), a_rise_cyc.size());
    end else begin
      checks++;
      if (a_done_cyc[0] != k2 + 36) begin
        failures++; $display("FAIL rstmid_retry_done cyc=%0d exp=%0d", a_done_cyc[0], k2 + 36);
      end
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (a_rise_sda[n] !== b[7-n] || a_rise_dc[n] !== 1'b1) begin
          failures++;
          $display("FAIL rstmid_retry_bit%0d sda=%b dc=%b exp sda=%b dc=1", n, a_rise_sda[n], a_rise_dc[n], b[7-n]);
        end
      end
    end
  endtask

  task automatic test_param_corner();
    int k1, k2, kk, m;
    logic [15:0] both;
    both = 16'hA55A;
    clear_logs();
    data_b = 9'h0A5; en_b = 1'b1; k1 = cyc + 1; k2 = k1 + 19;
    wait_cyc(k1 + 18);
    checks++;
    if (b_wr_done !== 1'b1 || b_cs_n !== 1'b1 || b_busy !== 1'b1) begin
      failures++;
      $display("FAIL corner_done wr_done=%b cs_n=%b busy=%b exp 1 1 1", b_wr_done, b_cs_n, b_busy);
    end
    data_b = 9'h15A;
    wait_cyc(k2); en_b = 1'b0;
    checks++;
    if (b_wr_done !== 1'b0 || b_cs_n !== 1'b0 || b_dc !== 1'b1) begin
      failures++;
      $display("FAIL corner_reaccept wr_done=%b cs_n=%b dc=%b exp 0 0 1", b_wr_done, b_cs_n, b_dc);
    end
    wait_cyc(k2 + 20);
    checks++;
    if (b_busy !== 1'b0) begin failures++; $display("FAIL corner_idle busy=%b exp 0", b_busy); end
    checks++;
    if (b_acc_cyc.size() != 2 || b_done_cyc.size() != 2 || b_rise_cyc.size() != 16) begin
      failures++;
      $display("FAIL corner_counts acc=%0d done=%0d rises=%0d exp 2 2 16",
               b_acc_cyc.size(), b_done_cyc.size(), b_rise_cyc.size());
    end else begin
      checks++;
      if (b_acc_cyc[1] != k2 || b_done_cyc[0] != k1 + 18 || b_done_cyc[1] != k2 + 18) begin
        failures++;
        $display("FAIL corner_timing acc2=%0d done=%0d,%0d exp %0d %0d,%0d",
                 b_acc_cyc[1], b_done_cyc[0], b_done_cyc[1], k2, k1 + 18, k2 + 18);
      end
      for (int n = 0; n < 16; n++) begin
        kk = (n < 8) ? k1 : k2;
        m = n % 8;
        checks++;
        if (b_rise_cyc[n] != kk + 2 * m + 1 || b_rise_sda[n] !== both[15-n] ||
            b_rise_dc[n] !== ((n < 8) ? 1'b0 : 1'b1)) begin
          failures++;
          $display("FAIL corner_rise%0d cyc=%0d sda=%b dc=%b exp cyc=%0d sda=%b dc=%b", n, b_rise_cyc[n],
                   b_rise_sda[n], b_rise_dc[n], kk + 2 * m + 1, both[15-n], (n < 8) ? 1'b0 : 1'b1);
        end
      end
    end
  endtask

  initial begin
    sys_rst = 1'b1; en_a = 1'b0; en_b = 1'b0; data_a = '0; data_b = '0;
    test_reset();
    test_single_cmd();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();
    test_param_corner();
    checks++;
    if (dc_err != 0) begin failures++; $display("FAIL dc_stable changes=%0d exp=0", dc_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
